// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the three-master Wishbone arbiter.
package wb_arbiter_pkg;

    localparam int unsigned NUM_MASTERS     = 3;
    localparam logic [1:0]  IDLE_OWNER      = 2'd3;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // Advance a master index modulo NUM_MASTERS.
    function automatic logic [1:0] rr_inc(input logic [1:0] v);
        return (v >= 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone bus bundle; "master" drives the request side, "slave" responds.
interface wb_arbiter_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_arb_rr.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_arb_rr
    import wb_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] owner,
    output logic       valid
);

    // Scan the three masters starting one past the previous owner.
    always_comb begin
        logic [1:0] w_idx;
        owner = '0;
        valid = 1'b0;
        w_idx = rr_inc(last);
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!valid && req[w_idx]) begin
                owner = w_idx;
                valid = 1'b1;
            end
            w_idx = rr_inc(w_idx);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Three-master Wishbone arbiter with round-robin grant and stall timeout.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_cyc_i, m0_stb_i, m0_we_i,
    input  logic [31:0] m0_adr_i, m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o, m0_err_o,
    input  logic        m1_cyc_i, m1_stb_i, m1_we_i,
    input  logic [31:0] m1_adr_i, m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o, m1_err_o,
    input  logic        m2_cyc_i, m2_stb_i, m2_we_i,
    input  logic [31:0] m2_adr_i, m2_dat_i,
    input  logic [3:0]  m2_sel_i,
    output logic [31:0] m2_dat_o,
    output logic        m2_ack_o, m2_err_o,
    output logic        s_cyc_o, s_stb_o, s_we_o,
    output logic [31:0] s_adr_o, s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i, s_err_i,
    output logic [1:0]  grant_o
);

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    arb_state_t  r_state, w_state_nxt;
    logic [1:0]  r_owner, w_owner_nxt;
    logic [1:0]  r_last, w_last_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;

    logic [1:0]  w_rr_owner;
    logic        w_rr_valid;
    logic        w_own_cyc, w_own_stb, w_own_we;
    logic [31:0] w_own_adr, w_own_dat;
    logic [3:0]  w_own_sel;
    logic        w_granted, w_stall, w_abort;

    wb_arbiter_if u_s_bus ();

    wb_arb_rr u_rr (
        .req   ({m2_cyc_i, m1_cyc_i, m0_cyc_i}),
        .last  (r_last),
        .owner (w_rr_owner),
        .valid (w_rr_valid)
    );

    // Select the current owner's request signals.
    always_comb begin
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        case (r_owner)
            2'd0: begin
                w_own_cyc = m0_cyc_i; w_own_stb = m0_stb_i; w_own_we = m0_we_i;
                w_own_adr = m0_adr_i; w_own_dat = m0_dat_i; w_own_sel = m0_sel_i;
            end
            2'd1: begin
                w_own_cyc = m1_cyc_i; w_own_stb = m1_stb_i; w_own_we = m1_we_i;
                w_own_adr = m1_adr_i; w_own_dat = m1_dat_i; w_own_sel = m1_sel_i;
            end
            2'd2: begin
                w_own_cyc = m2_cyc_i; w_own_stb = m2_stb_i; w_own_we = m2_we_i;
                w_own_adr = m2_adr_i; w_own_dat = m2_dat_i; w_own_sel = m2_sel_i;
            end
            default: ;
        endcase
    end

    // A stall cycle that would reach TIMEOUT aborts; an ack in that cycle is
    // not a stall, so it naturally takes priority over the timeout.
    assign w_granted = (r_state == GRANT);
    assign w_stall   = w_granted & w_own_cyc & w_own_stb & ~s_ack_i & ~s_err_i;
    assign w_abort   = w_stall & (r_cnt == TIMEOUT_M1);

    // Next-state, ownership and stall-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_rr_valid) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_rr_owner;
                end
            end
            GRANT: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                end else if (w_abort) begin
                    w_state_nxt = ABORT;
                end else if (w_stall) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ABORT: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_last  <= 2'd2;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign u_s_bus.cyc   = w_granted & w_own_cyc;
    assign u_s_bus.stb   = w_granted & w_own_stb;
    assign u_s_bus.we    = w_granted & w_own_we;
    assign u_s_bus.adr   = w_granted ? w_own_adr : '0;
    assign u_s_bus.dat_w = w_granted ? w_own_dat : '0;
    assign u_s_bus.sel   = w_granted ? w_own_sel : '0;
    assign u_s_bus.dat_r = s_dat_i;
    assign u_s_bus.ack   = s_ack_i;
    assign u_s_bus.err   = s_err_i;

    assign s_cyc_o = u_s_bus.cyc;
    assign s_stb_o = u_s_bus.stb;
    assign s_we_o  = u_s_bus.we;
    assign s_adr_o = u_s_bus.adr;
    assign s_dat_o = u_s_bus.dat_w;
    assign s_sel_o = u_s_bus.sel;

    assign m0_dat_o = u_s_bus.dat_r;
    assign m1_dat_o = u_s_bus.dat_r;
    assign m2_dat_o = u_s_bus.dat_r;

    assign m0_ack_o = u_s_bus.ack & w_granted & (r_owner == 2'd0);
    assign m1_ack_o = u_s_bus.ack & w_granted & (r_owner == 2'd1);
    assign m2_ack_o = u_s_bus.ack & w_granted & (r_owner == 2'd2);
    assign m0_err_o = ((u_s_bus.err & w_granted) | w_abort) & (r_owner == 2'd0);
    assign m1_err_o = ((u_s_bus.err & w_granted) | w_abort) & (r_owner == 2'd1);
    assign m2_err_o = ((u_s_bus.err & w_granted) | w_abort) & (r_owner == 2'd2);

    assign grant_o = (r_state == IDLE) ? IDLE_OWNER : r_owner;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one DUT with TIMEOUT=16, one with TIMEOUT=4,
// both driven from the same master/slave stimulus.
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [1:0] grant;
    int         checks = 0;
    int         failures = 0;

    wb_arbiter_if m0_if ();
    wb_arbiter_if m1_if ();
    wb_arbiter_if m2_if ();
    wb_arbiter_if s_if ();

    logic [31:0] d4_m0_dat, d4_m1_dat, d4_m2_dat, d4_s_adr, d4_s_dat;
    logic        d4_m0_ack, d4_m0_err, d4_m1_ack, d4_m1_err, d4_m2_ack, d4_m2_err;
    logic        d4_s_cyc, d4_s_stb, d4_s_we;
    logic [3:0]  d4_s_sel;
    logic [1:0]  d4_grant;

    always #5 clk = ~clk;

    wb_arbiter #(.TIMEOUT(16)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_if.cyc), .m0_stb_i(m0_if.stb), .m0_we_i(m0_if.we),
        .m0_adr_i(m0_if.adr), .m0_dat_i(m0_if.dat_w), .m0_sel_i(m0_if.sel),
        .m0_dat_o(m0_if.dat_r), .m0_ack_o(m0_if.ack), .m0_err_o(m0_if.err),
        .m1_cyc_i(m1_if.cyc), .m1_stb_i(m1_if.stb), .m1_we_i(m1_if.we),
        .m1_adr_i(m1_if.adr), .m1_dat_i(m1_if.dat_w), .m1_sel_i(m1_if.sel),
        .m1_dat_o(m1_if.dat_r), .m1_ack_o(m1_if.ack), .m1_err_o(m1_if.err),
        .m2_cyc_i(m2_if.cyc), .m2_stb_i(m2_if.stb), .m2_we_i(m2_if.we),
        .m2_adr_i(m2_if.adr), .m2_dat_i(m2_if.dat_w), .m2_sel_i(m2_if.sel),
        .m2_dat_o(m2_if.dat_r), .m2_ack_o(m2_if.ack), .m2_err_o(m2_if.err),
        .s_cyc_o(s_if.cyc), .s_stb_o(s_if.stb), .s_we_o(s_if.we),
        .s_adr_o(s_if.adr), .s_dat_o(s_if.dat_w), .s_sel_o(s_if.sel),
        .s_dat_i(s_if.dat_r), .s_ack_i(s_if.ack), .s_err_i(s_if.err),
        .grant_o(grant)
    );

    wb_arbiter #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_if.cyc), .m0_stb_i(m0_if.stb), .m0_we_i(m0_if.we),
        .m0_adr_i(m0_if.adr), .m0_dat_i(m0_if.dat_w), .m0_sel_i(m0_if.sel),
        .m0_dat_o(d4_m0_dat), .m0_ack_o(d4_m0_ack), .m0_err_o(d4_m0_err),
        .m1_cyc_i(m1_if.cyc), .m1_stb_i(m1_if.stb), .m1_we_i(m1_if.we),
        .m1_adr_i(m1_if.adr), .m1_dat_i(m1_if.dat_w), .m1_sel_i(m1_if.sel),
        .m1_dat_o(d4_m1_dat), .m1_ack_o(d4_m1_ack), .m1_err_o(d4_m1_err),
        .m2_cyc_i(m2_if.cyc), .m2_stb_i(m2_if.stb), .m2_we_i(m2_if.we),
        .m2_adr_i(m2_if.adr), .m2_dat_i(m2_if.dat_w), .m2_sel_i(m2_if.sel),
        .m2_dat_o(d4_m2_dat), .m2_ack_o(d4_m2_ack), .m2_err_o(d4_m2_err),
        .s_cyc_o(d4_s_cyc), .s_stb_o(d4_s_stb), .s_we_o(d4_s_we),
        .s_adr_o(d4_s_adr), .s_dat_o(d4_s_dat), .s_sel_o(d4_s_sel),
        .s_dat_i(s_if.dat_r), .s_ack_i(s_if.ack), .s_err_i(s_if.err),
        .grant_o(d4_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = '0; m0_if.dat_w = '0; m0_if.sel = '0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = '0; m1_if.dat_w = '0; m1_if.sel = '0;
        m2_if.cyc = 0; m2_if.stb = 0; m2_if.we = 0; m2_if.adr = '0; m2_if.dat_w = '0; m2_if.sel = '0;
        s_if.dat_r = '0; s_if.ack = 0; s_if.err = 0;

        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("rst_grant", grant, 32'd3);
        chk("rst_s_cyc", s_if.cyc, 0);
        chk("rst_s_stb", s_if.stb, 0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // Single read by m1
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h0000_1000; m1_if.sel = 4'hF;
        settle();
        chk("rd_pre_grant", grant, 32'd3);
        chk("rd_pre_scyc", s_if.cyc, 0);
        step();
        chk("rd_grant", grant, 32'd1);
        chk("rd_scyc", s_if.cyc, 1);
        chk("rd_sadr", s_if.adr, 32'h0000_1000);
        chk("rd_swe", s_if.we, 0);
        step();
        chk("rd_noack_early", m1_if.ack, 0);
        s_if.ack = 1; s_if.dat_r = 32'hDEAD_BEEF;
        settle();
        chk("rd_ack", m1_if.ack, 1);
        chk("rd_dat", m1_if.dat_r, 32'hDEAD_BEEF);
        chk("rd_m0_noack", m0_if.ack, 0);
        step();
        s_if.ack = 0;
        m1_if.cyc = 0; m1_if.stb = 0;
        settle();
        chk("rd_scyc_drop", s_if.cyc, 0);
        step();
        chk("rd_idle_grant", grant, 32'd3);

        // Three simultaneous requests from reset
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h100;
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h200;
        m2_if.cyc = 1; m2_if.stb = 1; m2_if.adr = 32'h300;
        step();
        chk("rr_g0", grant, 32'd0);
        chk("rr_adr0", s_if.adr, 32'h100);
        s_if.ack = 1;
        settle();
        chk("rr_ack0", m0_if.ack, 1);
        chk("rr_m1_wait", m1_if.ack, 0);
        chk("rr_m2_wait", m2_if.ack, 0);
        step();
        s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
        step();
        chk("rr_idle01", grant, 32'd3);
        chk("rr_idle01_scyc", s_if.cyc, 0);
        step();
        chk("rr_g1", grant, 32'd1);
        chk("rr_adr1", s_if.adr, 32'h200);
        s_if.ack = 1;
        settle();
        chk("rr_ack1", m1_if.ack, 1);
        step();
        s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
        step();
        chk("rr_idle12", grant, 32'd3);
        step();
        chk("rr_g2", grant, 32'd2);
        chk("rr_adr2", s_if.adr, 32'h300);
        s_if.ack = 1;
        settle();
        chk("rr_ack2", m2_if.ack, 1);
        step();
        s_if.ack = 0; m2_if.cyc = 0; m2_if.stb = 0;
        step();
        chk("rr_idle_end", grant, 32'd3);

        // m1 four-beat burst while m0 waits
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h400;
        step();
        chk("bu_g1", grant, 32'd1);
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            s_if.ack = 1; s_if.dat_r = 32'h1000 + i;
            settle();
            chk("bu_m1_ack", m1_if.ack, 1);
            chk("bu_m0_noack", m0_if.ack, 0);
            chk("bu_hold", grant, 32'd1);
            step();
        end
        s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
        settle();
        chk("bu_m0_noack_end", m0_if.ack, 0);
        step();
        chk("bu_idle", grant, 32'd3);
        step();
        chk("bu_g0", grant, 32'd0);
        chk("bu_adr0", s_if.adr, 32'h500);
        s_if.ack = 1;
        settle();
        chk("bu_m0_ack", m0_if.ack, 1);
        step();
        s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
        step();
        step();

        // m2 write never acked -> timeout at 16
        m2_if.cyc = 1; m2_if.stb = 1; m2_if.we = 1;
        m2_if.adr = 32'h2000; m2_if.dat_w = 32'h1234_5678; m2_if.sel = 4'h3;
        step();
        chk("to_g2", grant, 32'd2);
        chk("to_swe", s_if.we, 1);
        chk("to_sdat", s_if.dat_w, 32'h1234_5678);
        chk("to_ssel", s_if.sel, 32'h3);
        chk("to_noerr_c1", m2_if.err, 0);
        for (int i = 2; i <= 15; i++) begin
            step();
            chk("to_noerr", m2_if.err, 0);
        end
        step();
        chk("to_err16", m2_if.err, 1);
        chk("to_scyc16", s_if.cyc, 1);
        chk("to_m0_noerr", m0_if.err, 0);
        step();
        chk("to_err_once", m2_if.err, 0);
        chk("to_abort_scyc", s_if.cyc, 0);
        chk("to_abort_sstb", s_if.stb, 0);
        s_if.ack = 1;
        settle();
        chk("to_late_ack", m2_if.ack, 0);
        s_if.ack = 0;
        m2_if.cyc = 0; m2_if.stb = 0; m2_if.we = 0;
        step();
        chk("to_idle", grant, 32'd3);

        // TIMEOUT=4 instance: ack coincides with 4th stall
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h600;
        step();
        chk("co_g0", d4_grant, 32'd0);
        step();
        step();
        chk("co_noerr_c3", d4_m0_err, 0);
        step();
        s_if.ack = 1; s_if.dat_r = 32'hCAFE_F00D;
        settle();
        chk("co_ack", d4_m0_ack, 1);
        chk("co_err", d4_m0_err, 0);
        chk("co_dat", d4_m0_dat, 32'hCAFE_F00D);
        step();
        s_if.ack = 0;
        settle();
        chk("co_still_grant", d4_grant, 32'd0);
        chk("co_still_scyc", d4_s_cyc, 1);
        chk("co_noerr_after", d4_m0_err, 0);
        m0_if.cyc = 0; m0_if.stb = 0;
        step();
        step();

        // Reset during an m0 transfer
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h700;
        step();
        chk("rs_g0", grant, 32'd0);
        chk("rs_scyc", s_if.cyc, 1);
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h800;
        s_if.ack = 1;
        reset_n = 1'b0;
        #1;
        chk("rs_scyc_drop", s_if.cyc, 0);
        chk("rs_grant", grant, 32'd3);
        chk("rs_noack", m0_if.ack, 0);
        s_if.ack = 0;
        reset_n = 1'b1;
        step();
        chk("rs_next_g0", grant, 32'd0);
        chk("rs_next_adr", s_if.adr, 32'h700);
        m0_if.cyc = 0; m0_if.stb = 0;
        m1_if.cyc = 0; m1_if.stb = 0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: stalled-cycle limit before bus abort (1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, for N=0..2, ports mN_cyc_i/mN_stb_i/mN_we_i  input  1 each  Wishbone master cycle/strobe/write.
REQ-005 SHALL have, for N=0..2, ports mN_adr_i  input  32 and mN_dat_i  input  32: master address and write data.
REQ-006 SHALL have, for N=0..2, port mN_sel_i  input  4  byte selects.
REQ-007 SHALL have, for N=0..2, ports mN_dat_o  output  32, mN_ack_o  output  1, mN_err_o  output  1: read data, ack, error.
REQ-008 SHALL have ports s_cyc_o/s_stb_o/s_we_o  output  1 each, s_adr_o/s_dat_o  output  32, s_sel_o  output  4: shared slave bus.
REQ-009 SHALL have ports s_dat_i  input  32, s_ack_i  input  1, s_err_i  input  1: slave response.
REQ-010 SHALL have port grant_o  output  2  current owner (0..2), 3 when idle.
Master 0 = LM32 instruction bus, master 1 = LM32 data bus, master 2 = spare (debug/DMA).

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, ABORT.
REQ-012 IDLE: if any mN_cyc_i high, SHALL register the owner chosen round-robin and enter GRANT next cycle; else stay IDLE.
REQ-013 Round-robin SHALL search starting at (last_owner+1) mod 3; after reset last_owner=2, so master 0 has first priority.
REQ-014 Grant latency SHALL be exactly 1 cycle: cyc_i seen at edge t, s_cyc_o high from edge t onward (registered grant).
REQ-015 GRANT: s_* outputs SHALL mirror the owner's inputs; non-owners SHALL see ack_o=0, err_o=0.
REQ-016 mN_ack_o SHALL equal s_ack_i & owner==N & state==GRANT (combinational); mN_err_o likewise from s_err_i, ORed with abort pulse.
REQ-017 All mN_dat_o SHALL be driven from s_dat_i (no muxing needed; ack qualifies).
REQ-018 Grant SHALL be held while owner cyc_i high (multi-beat/RMW cycles not interruptible); owner cyc_i low -> IDLE next cycle, last_owner updated.
REQ-019 Ownership handover SHALL always pass through one IDLE cycle (no GRANT->GRANT).
REQ-020 Stall counter (8 bit) SHALL increment each GRANT cycle with owner stb_i high and s_ack_i=s_err_i=0; SHALL clear on ack, err, stb low, or leaving GRANT.
REQ-021 Counter reaching TIMEOUT SHALL assert owner mN_err_o for exactly one cycle and enter ABORT.
REQ-022 ABORT: s_cyc_o=s_stb_o=0, late s_ack_i ignored; exit to IDLE when owner cyc_i low.
REQ-023 Owner dropping cyc_i mid-stall SHALL abandon transfer without err; ack and timeout in same cycle SHALL give ack priority.
REQ-024 Non-owners requesting SHALL wait without error; no request is lost while cyc_i held.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, last_owner=2, counter=0, grant_o=3, all s_*_o and mN_ack_o/mN_err_o low.
REQ-026 Reset mid-transfer SHALL drop s_cyc_o immediately; no ack/err delivered afterwards.

Structure
REQ-027 Package wb_arbiter_pkg SHALL hold the FSM state enum, NUM_MASTERS=3, IDLE_OWNER=2'd3, default TIMEOUT.
REQ-028 Round-robin selection SHALL be a combinational sub-module wb_arb_rr (req[2:0], last[1:0] -> owner[1:0], valid).

Verification
REQ-029 Reset, m1 read adr 0x0000_1000; slave acks 2 cycles later with 0xDEADBEEF -> grant_o=1 one cycle after cyc, m1_dat_o=0xDEADBEEF with m1_ack_o, grant_o=3 after cyc drops.
REQ-030 m0, m1, m2 request together from reset -> grants in order 0,1,2, each separated by one IDLE cycle.
REQ-031 m1 holds cyc for 4 beats while m0 requests -> m0 granted only after m1 cyc low; m0 acks never asserted earlier.
REQ-032 TIMEOUT=16, slave never acks m2 write -> m2_err_o single pulse on 16th stalled cycle, s_cyc_o low next, late s_ack_i not forwarded.
REQ-033 reset_n pulsed low during m0 granted transfer -> s_cyc_o low same time step, grant_o=3, next grant goes to m0.
REQ-034 s_ack_i and timeout coincide (TIMEOUT=4, ack on 4th stall) -> m_ack_o=1, m_err_o=0, state stays GRANT.
